// File: rtl/light_countdown.sv
// Countdown display and pedestrian head driven by the light FSM lamps.
// Ports: clk, rst, tick, r/g/y in; tens, units, blank, walk, dont_walk, fault, timing_err out.
module light_countdown #(
  parameter int RED_S   = 30,
  parameter int GRN_S   = 25,
  parameter int YEL_S   = 5,
  parameter int FLASH_S = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       r,
  input  logic       g,
  input  logic       y,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       blank,
  output logic       walk,
  output logic       dont_walk,
  output logic       fault,
  output logic       timing_err
);

  typedef enum logic [2:0] {
    IDLE,
    RUN_R,
    RUN_G,
    RUN_Y,
    FAULT
  } state_t;

  state_t     state, nxt_state;
  logic [6:0] rem, nxt_rem;
  logic [2:0] lamp_q;
  logic [2:0] code;
  logic       flash_ph, nxt_flash;
  logic       chg;
  logic       running;
  logic       set_err;

  assign code    = {r, g, y};
  assign chg     = code != lamp_q;
  assign running = (state == RUN_R) ||
                   (state == RUN_G) ||
                   (state == RUN_Y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      lamp_q   <= '0;
      flash_ph <= 1'b1;
    end else begin
      state    <= nxt_state;
      rem      <= nxt_rem;
      lamp_q   <= code;
      flash_ph <= nxt_flash;
    end
  end

  // A lamp change always reloads; a tick in that cycle is dropped.
  always_comb begin
    nxt_state = state;
    nxt_rem   = rem;
    nxt_flash = flash_ph;
    set_err   = 1'b0;
    if (chg) begin
      unique case (code)
        3'b100: begin
          nxt_state = RUN_R;
          nxt_rem   = 7'(RED_S);
          nxt_flash = 1'b1;
        end
        3'b010: begin
          nxt_state = RUN_G;
          nxt_rem   = 7'(GRN_S);
        end
        3'b001: begin
          nxt_state = RUN_Y;
          nxt_rem   = 7'(YEL_S);
        end
        default: begin
          nxt_state = FAULT;
          nxt_rem   = '0;
        end
      endcase
    end else if (running && tick) begin
      if (rem == 7'd0) set_err = 1'b1;
      else nxt_rem = rem - 7'd1;
      if (state == RUN_R && rem <= 7'(FLASH_S))
        nxt_flash = ~flash_ph;
    end
  end

  // Outputs are a second register stage fed from the state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens       <= 4'hF;
      units      <= 4'hF;
      blank      <= 1'b1;
      walk       <= 1'b0;
      dont_walk  <= 1'b1;
      fault      <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      fault <= state == FAULT;
      if (set_err) timing_err <= 1'b1;
      if (running) begin
        tens  <= 4'(rem / 7'd10);
        units <= 4'(rem % 7'd10);
        blank <= 1'b0;
      end else begin
        tens  <= 4'hF;
        units <= 4'hF;
        blank <= 1'b1;
      end
      if (state == RUN_R) begin
        dont_walk <= 1'b0;
        walk      <= (rem > 7'(FLASH_S)) ? 1'b1 : flash_ph;
      end else begin
        dont_walk <= 1'b1;
        walk      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_light_countdown.sv
// Directed bench for light_countdown: vector table plus hand sequences.
// Covers load latency, flashing walk, tick/load collision, overrun, faults, reset.
module tb_light_countdown;

  logic       clk = 1'b0;
  logic       rst, tick, r, g, y;
  logic [3:0] tens, units;
  logic       blank, walk, dont_walk, fault, timing_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [2:0] rgy;
    logic [3:0] tens;
    logic [3:0] units;
    logic       blank;
    logic       walk;
    logic       dw;
    logic       fault;
    logic       terr;
  } vec_t;

  vec_t tbl[18];

  light_countdown dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .r          (r),
    .g          (g),
    .y          (y),
    .tens       (tens),
    .units      (units),
    .blank      (blank),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .fault      (fault),
    .timing_err (timing_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic       rs,
    input logic       tk,
    input logic [2:0] c,
    input logic [3:0] t,
    input logic [3:0] u,
    input logic       b,
    input logic       w,
    input logic       d,
    input logic       f,
    input logic       e
  );
    vec_t v;
    v.rst = rs; v.tick = tk; v.rgy = c;
    v.tens = t; v.units = u; v.blank = b;
    v.walk = w; v.dw = d; v.fault = f;
    v.terr = e;
    return v;
  endfunction

  task automatic step(
    input logic       rs,
    input logic       tk,
    input logic [2:0] c
  );
    rst = rs;
    tick = tk;
    {r, g, y} = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      name,
    input logic [3:0] t,
    input logic [3:0] u,
    input logic       b,
    input logic       w,
    input logic       d,
    input logic       f,
    input logic       e
  );
    logic [14:0] act, exp;
    act = {tens, units, blank, walk, dont_walk, fault, timing_err};
    exp = {t, u, b, w, d, f, e};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got t/u=%h/%h b=%b w=%b dw=%b f=%b te=%b want t/u=%h/%h b=%b w=%b dw=%b f=%b te=%b",
               name, tens, units, blank, walk, dont_walk, fault,
               timing_err, t, u, b, w, d, f, e);
    end
  endtask

  initial begin
    int rv;
    logic [6:0] rm;

    // Red at 0, green collides with tick, yellow overrun, fault, recover.
    tbl[0]  = mk(0, 1, 3'b010, 4'd0, 4'd0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 3'b010, 4'd2, 4'd5, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 3'b001, 4'd2, 4'd4, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 3'b001, 4'd0, 4'd5, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 3'b001, 4'd0, 4'd4, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 3'b001, 4'd0, 4'd3, 0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 3'b001, 4'd0, 4'd2, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 3'b001, 4'd0, 4'd1, 0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 3'b001, 4'd0, 4'd0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(0, 1, 3'b001, 4'd0, 4'd0, 0, 0, 1, 0, 1);
    tbl[10] = mk(0, 1, 3'b001, 4'd0, 4'd0, 0, 0, 1, 0, 1);
    tbl[11] = mk(0, 0, 3'b100, 4'd0, 4'd0, 0, 0, 1, 0, 1);
    tbl[12] = mk(0, 0, 3'b100, 4'd3, 4'd0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 3'b110, 4'd3, 4'd0, 0, 1, 0, 0, 1);
    tbl[14] = mk(0, 0, 3'b110, 4'hF, 4'hF, 1, 0, 1, 1, 1);
    tbl[15] = mk(0, 0, 3'b110, 4'hF, 4'hF, 1, 0, 1, 1, 1);
    tbl[16] = mk(0, 0, 3'b010, 4'hF, 4'hF, 1, 0, 1, 1, 1);
    tbl[17] = mk(0, 0, 3'b010, 4'd2, 4'd5, 0, 0, 1, 0, 1);

    step(1, 0, 3'b000);
    chk("reset", 4'hF, 4'hF, 1, 0, 1, 0, 0);
    step(0, 1, 3'b000);
    chk("idle_000", 4'hF, 4'hF, 1, 0, 1, 0, 0);

    // Red with tick tied high: blank on edge 1, 30 on edge 2, then down.
    for (int n = 1; n <= 31; n++) begin
      step(0, 1, 3'b100);
      if (n == 1) begin
        chk("red_lat", 4'hF, 4'hF, 1, 0, 1, 0, 0);
      end else begin
        rv = 32 - n;
        rm = 7'(rv);
        chk($sformatf("red_%0d", rv), 4'(rv / 10), 4'(rv % 10), 0,
            (rv > 5) ? 1'b1 : rm[0], 0, 0, 0);
      end
    end

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].tick, tbl[i].rgy);
      chk($sformatf("vec_%0d", i), tbl[i].tens, tbl[i].units,
          tbl[i].blank, tbl[i].walk, tbl[i].dw, tbl[i].fault,
          tbl[i].terr);
    end

    // Green counts from 25 down to 13 shown (12 held internally).
    for (int k = 0; k <= 12; k++) begin
      step(0, 1, 3'b010);
      rv = 25 - k;
      chk($sformatf("grn_%0d", rv), 4'(rv / 10), 4'(rv % 10),
          0, 0, 1, 0, 1);
    end

    // Mid-phase reset with green held: blank, then reload to 25.
    step(1, 0, 3'b010);
    chk("rst_mid", 4'hF, 4'hF, 1, 0, 1, 0, 0);
    step(0, 0, 3'b010);
    chk("rst_lat", 4'hF, 4'hF, 1, 0, 1, 0, 0);
    step(0, 0, 3'b010);
    chk("rst_reload", 4'd2, 4'd5, 0, 0, 1, 0, 0);
    step(0, 1, 3'b000);
    chk("run_000", 4'd2, 4'd5, 0, 0, 1, 0, 0);
    step(0, 1, 3'b000);
    chk("fault_000", 4'hF, 4'hF, 1, 0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
